// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
//
// Purpose:
//   64-bit integer ALU for the multicycle datapath. Computes one of eight
//   operations on srcA/srcB and registers both the result and a zero flag,
//   so the controller reads them in the cycle after the operands are applied.
//   The zero flag feeds branch decisions; the result feeds ALUOut / PC update.
//
// Ports:
//   clk     in   1      rising-edge clock, single domain
//   reset   in   1      synchronous, active-high; result <= 0, zero <= 1
//   srcA    in   WIDTH  operand A
//   srcB    in   WIDTH  operand B (shifts use srcB[5:0] only)
//   ALU_Op  in   3      000 ADD, 001 SUB, 010 AND, 011 OR,
//                       100 XOR, 101 SLT (signed), 110 SLL, 111 SRL
//   result  out  WIDTH  registered result, 1-cycle latency
//   zero    out  1      registered flag, 1 when result == 0
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       ALU_Op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Zero detect on a full-width value.
  function automatic logic is_zero(input logic [WIDTH-1:0] value);
    is_zero = ~(|value);
  endfunction

  logic [5:0]       shamt_s;
  logic             slt_s;
  logic [WIDTH-1:0] next_result_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;

  // Only the low six bits of B select a shift; upper bits are ignored.
  assign shamt_s = srcB[5:0];
  assign slt_s   = ($signed(srcA) < $signed(srcB));

  // Next-result selection; ADD/SUB wrap modulo 2^WIDTH with no overflow flag.
  always_comb begin
    next_result_s = {WIDTH{1'b0}};
    case (ALU_Op)
      3'b000:  next_result_s = srcA + srcB;
      3'b001:  next_result_s = srcA - srcB;
      3'b010:  next_result_s = srcA & srcB;
      3'b011:  next_result_s = srcA | srcB;
      3'b100:  next_result_s = srcA ^ srcB;
      3'b101:  next_result_s = {{(WIDTH-1){1'b0}}, slt_s};
      3'b110:  next_result_s = srcA << shamt_s;
      3'b111:  next_result_s = srcA >> shamt_s;
      default: next_result_s = {WIDTH{1'b0}};
    endcase
  end

  // Output register; zero is derived from the same next value so the pair
  // is always consistent. Reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b1;
    end else begin
      result_r <= next_result_s;
      zero_r   <= is_zero(next_result_s);
    end
  end

  assign result = result_r;
  assign zero   = zero_r;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
//
// Self-checking bench for alu. Directed scenarios plus randomized operations
// compared against an arithmetic reference model. Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point, i.e. after the
// edge that registered the previously applied operands.
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        reset;
  logic [63:0] srcA;
  logic [63:0] srcB;
  logic [2:0]  ALU_Op;
  logic [63:0] result;
  logic        zero;

  int checks;
  int errors;

  alu dut (
    .clk    (clk),
    .reset  (reset),
    .srcA   (srcA),
    .srcB   (srcB),
    .ALU_Op (ALU_Op),
    .result (result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic. Shifts are expressed as multiply /
  // divide by a power of two, SLT as a signed 64-bit integer compare.
  function automatic logic [63:0] ref_alu(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [2:0]  op);
    longint      sa;
    longint      sb;
    int          sh;
    logic [63:0] pow2;
    sa   = a;
    sb   = b;
    sh   = int'(b % 64'd64);
    pow2 = 64'd1;
    for (int i = 0; i < sh; i++) pow2 = pow2 * 64'd2;
    case (op)
      3'd0:    ref_alu = a + b;
      3'd1:    ref_alu = a - b;
      3'd2:    ref_alu = a & b;
      3'd3:    ref_alu = a | b;
      3'd4:    ref_alu = a ^ b;
      3'd5:    ref_alu = (sa < sb) ? 64'd1 : 64'd0;
      3'd6:    ref_alu = a * pow2;
      3'd7:    ref_alu = a / pow2;
      default: ref_alu = 64'd0;
    endcase
  endfunction

  // Drive operands, then advance past the next rising edge.
  task automatic drive_step(input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] op);
    srcA   = a;
    srcB   = b;
    ALU_Op = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    srcA   = 64'd123;
    srcB   = 64'd456;
    ALU_Op = 3'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result !== 64'd0 || zero !== 1'b1) begin
        errors++;
        $display("FAIL reset_edge%0d: result=%h zero=%b, expected result=0 zero=1",
                 i, result, zero);
      end
    end
    reset = 1'b0;
    drive_step(64'd6, 64'd4, 3'd0);
    checks++;
    if (result !== 64'd10 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: result=%0d zero=%b, expected result=10 zero=0",
               result, zero);
    end
  endtask

  task automatic test_arith_wrap();
    drive_step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0);
    checks++;
    if (result !== 64'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: result=%h zero=%b, expected 0 / 1", result, zero);
    end
    drive_step(64'd0, 64'd1, 3'd1);
    checks++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFFF || zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: result=%h zero=%b, expected ffffffffffffffff / 0",
               result, zero);
    end
  endtask

  task automatic test_logic();
    logic [63:0] exp_v [3];
    logic [2:0]  ops   [3];
    exp_v[0] = 64'h00F0; ops[0] = 3'd2;
    exp_v[1] = 64'hFFF0; ops[1] = 3'd3;
    exp_v[2] = 64'hFF00; ops[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      drive_step(64'hF0F0, 64'h0FF0, ops[i]);
      checks++;
      if (result !== exp_v[i] || zero !== 1'b0) begin
        errors++;
        $display("FAIL logic_op%0d: result=%h zero=%b, expected %h / 0",
                 ops[i], result, zero, exp_v[i]);
      end
    end
  endtask

  task automatic test_slt();
    logic [63:0] a_v   [3];
    logic [63:0] b_v   [3];
    logic [63:0] exp_v [3];
    a_v[0] = 64'hFFFF_FFFF_FFFF_FFFF; b_v[0] = 64'd1;                  exp_v[0] = 64'd1;
    a_v[1] = 64'd1;                  b_v[1] = 64'hFFFF_FFFF_FFFF_FFFF; exp_v[1] = 64'd0;
    a_v[2] = 64'd5;                  b_v[2] = 64'd5;                  exp_v[2] = 64'd0;
    for (int i = 0; i < 3; i++) begin
      drive_step(a_v[i], b_v[i], 3'd5);
      checks++;
      if (result !== exp_v[i] || zero !== (exp_v[i] == 64'd0)) begin
        errors++;
        $display("FAIL slt_case%0d: result=%h zero=%b, expected %h / %b",
                 i, result, zero, exp_v[i], (exp_v[i] == 64'd0));
      end
    end
  endtask

  task automatic test_shifts();
    drive_step(64'd1, 64'd63, 3'd6);
    checks++;
    if (result !== 64'h8000_0000_0000_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL sll_63: result=%h zero=%b, expected 8000000000000000 / 0",
               result, zero);
    end
    drive_step(64'h8000_0000_0000_0000, 64'h40, 3'd7);
    checks++;
    if (result !== 64'h8000_0000_0000_0000 || zero !== 1'b0) begin
      errors++;
      $display("FAIL srl_b40: result=%h zero=%b, expected 8000000000000000 / 0",
               result, zero);
    end
    drive_step(64'h8000_0000_0000_0000, 64'd63, 3'd7);
    checks++;
    if (result !== 64'd1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL srl_63: result=%h zero=%b, expected 1 / 0", result, zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a_v   [3];
    logic [63:0] b_v   [3];
    logic [2:0]  ops   [3];
    logic [63:0] exp_v [3];
    logic        expz  [3];
    a_v[0] = 64'd6; b_v[0] = 64'd4; ops[0] = 3'd0; exp_v[0] = 64'd10; expz[0] = 1'b0;
    a_v[1] = 64'd6; b_v[1] = 64'd6; ops[1] = 3'd1; exp_v[1] = 64'd0;  expz[1] = 1'b1;
    a_v[2] = 64'd0; b_v[2] = 64'd0; ops[2] = 3'd3; exp_v[2] = 64'd0;  expz[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_step(a_v[i], b_v[i], ops[i]);
      checks++;
      if (result !== exp_v[i] || zero !== expz[i]) begin
        errors++;
        $display("FAIL b2b_step%0d: result=%h zero=%b, expected %h / %b",
                 i, result, zero, exp_v[i], expz[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive_step(64'd7, 64'd8, 3'd0);
    reset = 1'b1;
    drive_step(64'd100, 64'd1, 3'd0);
    checks++;
    if (result !== 64'd0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: result=%h zero=%b, expected 0 / 1",
               result, zero);
    end
    reset = 1'b0;
    drive_step(64'd100, 64'd1, 3'd1);
    checks++;
    if (result !== 64'd99 || zero !== 1'b0) begin
      errors++;
      $display("FAIL midstream_release: result=%0d zero=%b, expected 99 / 0",
               result, zero);
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] exp_r;
    for (int i = 0; i < 300; i++) begin
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       b = a;
        1:       a = 64'd0;
        2:       b = {58'($urandom()), 6'd63};
        default: ;
      endcase
      exp_r = ref_alu(a, b, op);
      drive_step(a, b, op);
      checks++;
      if (result !== exp_r || zero !== (exp_r == 64'd0)) begin
        errors++;
        $display("FAIL random%0d op=%0d a=%h b=%h: result=%h zero=%b, expected %h / %b",
                 i, op, a, b, result, zero, exp_r, (exp_r == 64'd0));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    srcA   = 64'd0;
    srcB   = 64'd0;
    ALU_Op = 3'd0;
    test_reset();
    test_arith_wrap();
    test_logic();
    test_slt();
    test_shifts();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
